pa_soc_wb_arb: RTL

Write-back arbiter and scoreboard for the integer register file's single write port. It shares that port between NUM_REQ execution units (ALU, LSU, MDU) with valid/ready handshakes and round-robin fairness. It also tracks a per-register busy bit so decode can stall on RAW hazards. It sits between the execute stages and the register file: rd_addr, rd_data and rd_data_vld drive the register-file write port directly.

---
 rtl/pa_soc_param.sv | 9 +
 rtl/pa_soc_wb_arb_if.sv | 13 +
 rtl/pa_soc_rr_arb.sv | 34 +++
 rtl/pa_soc_wb_arb.sv | 87 ++++++++
 4 files changed

// File: rtl/pa_soc_param.sv
// pa_soc_param: shared register-file and write-back widths used across the SoC slice
package pa_soc_param;
  localparam int REG_BUS_WIDTH = 5;
  localparam int DATA_BUS_WIDTH = 32;
  localparam int REG_NUM = 32;
  localparam logic [DATA_BUS_WIDTH-1:0] ZERO_WORD = '0;
  localparam int WB_REQ_NUM = 3;
  typedef logic [REG_BUS_WIDTH-1:0] reg_idx_t;
endpackage

// File: rtl/pa_soc_wb_arb_if.sv
// pa_soc_wb_arb_if: write-back request bus, NUM_REQ requesters packed side by side
//   wb_vld/wb_rdy: per-requester handshake; wb_addr: 5 bits per requester; wb_data: DATA_W bits per requester
//   master: execution units; slave: the write-back arbiter
interface pa_soc_wb_arb_if
  import pa_soc_param::*;
#(parameter int NUM_REQ = WB_REQ_NUM, parameter int DATA_W = DATA_BUS_WIDTH);
  logic [NUM_REQ-1:0] wb_vld;
  logic [NUM_REQ-1:0] wb_rdy;
  logic [NUM_REQ*REG_BUS_WIDTH-1:0] wb_addr;
  logic [NUM_REQ*DATA_W-1:0] wb_data;
  modport master (output wb_vld, wb_addr, wb_data, input wb_rdy);
  modport slave (input wb_vld, wb_addr, wb_data, output wb_rdy);
endinterface

// File: rtl/pa_soc_rr_arb.sv
// pa_soc_rr_arb: N-way round-robin grant, combinational pick plus registered pointer
//   clk_i, rst_n_i (async, active-low); req: requests; gnt: one-hot grant; gnt_idx/gnt_vld: granted index and any-grant
module pa_soc_rr_arb #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_vld
);
  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  // walk from the farthest slot back towards ptr so the closest request wins last
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
        gnt_idx = idx;
      end
    end
  end
  assign gnt_vld = |req;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) ptr <= '0;
    else if (gnt_vld) ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
endmodule

// File: rtl/pa_soc_wb_arb.sv
// pa_soc_wb_arb: register-file write-port arbiter with RAW busy scoreboard
//   clk_i, rst_n_i (async, active-low); wb: requester bus (slave); iss_vld/iss_addr: destination issued by decode
//   rs1_addr/rs2_addr -> rs_busy: stall query; rd_addr/rd_data/rd_data_vld: register-file write port; flush: clear scoreboard
//   PA_SOC_WB_BYPASS_EN: adds byp1/byp2 forwarding of the in-flight write and drops it from rs_busy
module pa_soc_wb_arb
  import pa_soc_param::*;
#(
  parameter int NUM_REQ = WB_REQ_NUM,
  parameter int DATA_W = DATA_BUS_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  pa_soc_wb_arb_if.slave    wb,
  input  logic              iss_vld,
  input  reg_idx_t          iss_addr,
  input  reg_idx_t          rs1_addr,
  input  reg_idx_t          rs2_addr,
  input  logic              flush,
  output logic              rs_busy,
  output reg_idx_t          rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_vld
`ifdef PA_SOC_WB_BYPASS_EN
  ,
  output logic              byp1_vld,
  output logic              byp2_vld,
  output logic [DATA_W-1:0] byp1_data,
  output logic [DATA_W-1:0] byp2_data
`endif
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      g_idx;
  logic               g_vld;
  reg_idx_t           g_addr;
  logic [DATA_W-1:0]  g_data;
  logic               g_wr;
  logic [REG_NUM-1:0] busy;
  logic [REG_NUM-1:0] set_m;
  logic [REG_NUM-1:0] clr_m;
  logic               fwd1;
  logic               fwd2;
  pa_soc_rr_arb #(.N(NUM_REQ)) u_arb (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .req     (wb.wb_vld),
    .gnt     (gnt),
    .gnt_idx (g_idx),
    .gnt_vld (g_vld)
  );
  assign wb.wb_rdy = gnt;
  assign g_addr = wb.wb_addr[int'(g_idx)*REG_BUS_WIDTH +: REG_BUS_WIDTH];
  assign g_data = wb.wb_data[int'(g_idx)*DATA_W +: DATA_W];
  // x0 writes complete the handshake but never reach the register file
  assign g_wr = g_vld && (g_addr != '0);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      rd_data_vld <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
    end else begin
      rd_data_vld <= g_wr;
      if (g_wr) begin
        rd_addr <= g_addr;
        rd_data <= g_data;
      end
    end
  // set is applied after clear so a same-cycle issue keeps the register busy; bit 0 is forced clear
  assign set_m = (iss_vld && !flush) ? REG_NUM'(1) << iss_addr : '0;
  assign clr_m = g_vld ? REG_NUM'(1) << g_addr : '0;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) busy <= '0;
    else busy <= flush ? '0 : ((busy & ~clr_m) | set_m) & ~REG_NUM'(1);
  // rd_data_vld implies rd_addr != 0, so x0 never matches
  assign fwd1 = rd_data_vld && (rd_addr == rs1_addr);
  assign fwd2 = rd_data_vld && (rd_addr == rs2_addr);
`ifdef PA_SOC_WB_BYPASS_EN
  assign rs_busy = busy[rs1_addr] | busy[rs2_addr];
  assign byp1_vld = fwd1;
  assign byp2_vld = fwd2;
  assign byp1_data = rd_data;
  assign byp2_data = rd_data;
`else
  // the register file commits one cycle after rd_data_vld, so the in-flight write still stalls
  assign rs_busy = busy[rs1_addr] | busy[rs2_addr] | fwd1 | fwd2;
`endif
endmodule
